// File: rtl/buzzer_morse_gen_pkg.sv
// Shared command codes, FSM encoding and Morse element timing for the buzzer Morse generator.
package buzzer_morse_gen_pkg;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_O    = 2'b01;
    localparam logic [1:0] CMD_S    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ON       = 3'd1,
        ST_OFF      = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    localparam int unsigned NUM_ELEMENTS = 3;
    localparam int unsigned DOT_UNITS    = 1;
    localparam int unsigned DASH_UNITS   = 3;
    localparam int unsigned GAP_UNITS    = 1;

    // Counter width able to hold 0..terminal-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/buzzer_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLK_FREQ/1000 clocks, restarted by clear.
module buzzer_ms_tick
    import buzzer_morse_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned PW  = cnt_width(DIV);

    logic [PW-1:0] cnt_q;
    logic          wrap_c;

    assign wrap_c = (cnt_q == PW'(DIV - 1));
    assign tick   = !clear && wrap_c;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else if (clear || wrap_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/buzzer_morse_gen.sv
// Plays Morse S (three dots) or O (three dashes) on a buzzer pin, then flags completion
// until the controller withdraws its command.
module buzzer_morse_gen
    import buzzer_morse_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned T_UNIT_MS = 100,
    parameter int unsigned TONE_HZ   = 2000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [1:0] Start_Sig,
    output logic       Done_Sig,
    output logic       Pin_Out
);

    localparam int unsigned HALF = (TONE_HZ > 0 && CLK_FREQ / (2 * TONE_HZ) > 0)
                                 ? CLK_FREQ / (2 * TONE_HZ) : 1;
    localparam int unsigned MW   = cnt_width(T_UNIT_MS);
    localparam int unsigned UW   = cnt_width(DASH_UNITS);
    localparam int unsigned EW   = cnt_width(NUM_ELEMENTS);
    localparam int unsigned TW   = cnt_width(HALF);

    state_t        state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [EW-1:0] elem_q, elem_d;
    logic [MW-1:0] ms_q, ms_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [TW-1:0] tone_q, tone_d;
    logic          pin_q, pin_d;
    logic          done_q, done_d;

    logic          tick;
    logic          tick_clear_c;
    logic [UW-1:0] last_unit_c;
    logic          unit_end_c;
    logic          phase_end_c;
    logic          abort_c;

    assign tick_clear_c = (state_q == ST_IDLE);

    buzzer_ms_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .clear (tick_clear_c),
        .tick  (tick)
    );

    assign Pin_Out  = pin_q;
    assign Done_Sig = done_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            elem_q  <= '0;
            ms_q    <= '0;
            unit_q  <= '0;
            tone_q  <= '0;
            pin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            elem_q  <= elem_d;
            ms_q    <= ms_d;
            unit_q  <= unit_d;
            tone_q  <= tone_d;
            pin_q   <= pin_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        elem_d  = elem_q;
        ms_d    = ms_q;
        unit_d  = unit_q;
        tone_d  = tone_q;
        pin_d   = 1'b0;
        done_d  = 1'b0;

        abort_c     = (Start_Sig == CMD_NONE);
        last_unit_c = (state_q != ST_ON) ? UW'(GAP_UNITS - 1)
                    : (cmd_q == CMD_O)   ? UW'(DASH_UNITS - 1)
                    :                      UW'(DOT_UNITS - 1);
        unit_end_c  = tick && (ms_q == MW'(T_UNIT_MS - 1));
        phase_end_c = unit_end_c && (unit_q == last_unit_c);

        // ms and unit counters run only while a pattern is being played
        if ((state_q == ST_ON || state_q == ST_OFF) && tick) begin
            ms_d = unit_end_c ? '0 : ms_q + 1'b1;
            if (unit_end_c) begin
                unit_d = phase_end_c ? '0 : unit_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!abort_c) begin
                    cmd_d   = Start_Sig[1] ? CMD_S : CMD_O;
                    elem_d  = '0;
                    ms_d    = '0;
                    unit_d  = '0;
                    tone_d  = '0;
                    pin_d   = 1'b1;
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (abort_c) begin
                    state_d = ST_IDLE;
                end else if (phase_end_c) begin
                    state_d = ST_OFF;
                end else if (TONE_HZ == 0) begin
                    pin_d = 1'b1;
                end else if (tone_q == TW'(HALF - 1)) begin
                    pin_d  = ~pin_q;
                    tone_d = '0;
                end else begin
                    pin_d  = pin_q;
                    tone_d = tone_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (abort_c) begin
                    state_d = ST_IDLE;
                end else if (phase_end_c) begin
                    if (elem_q == EW'(NUM_ELEMENTS - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        elem_d  = elem_q + 1'b1;
                        tone_d  = '0;
                        pin_d   = 1'b1;
                        state_d = ST_ON;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                // no restart until the controller releases its command
                if (abort_c) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/buzzer_morse_gen.md
BUZZER_MORSE_GEN -- requirements
Module: buzzer_morse_gen

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, CLK frequency in Hz.
REQ-002 Parameter T_UNIT_MS, default 100, Morse unit length in ms.
REQ-003 Parameter TONE_HZ, default 2000, tone frequency in Hz during sound; 0 = steady high level.
REQ-004 CLK  input  1  system clock, rising edge.
REQ-005 RSTn  input  1  reset, asynchronous, active-low.
REQ-006 Start_Sig  input  2  command from the buzzer controller: 2'b10 = S, 2'b01 = O, 2'b00 = none.
REQ-007 Done_Sig  output  1  completion flag, registered, held until Start_Sig returns to 2'b00.
REQ-008 Pin_Out  output  1  buzzer drive, registered, high = sounding.

Function
REQ-009 States SHALL be IDLE, ON, OFF, DONE, WAIT_REL.
- IDLE: Pin_Out=0, Done_Sig=0.
- On Start_Sig != 0: latch command, clear all counters, element=0, go to ON.
- Start_Sig=2'b11 SHALL decode as S (bit1 priority).
REQ-010 A 1 ms tick SHALL come from a prescaler counting CLK_FREQ/1000 cycles; prescaler restarts on IDLE->ON.
- Unit counter counts T_UNIT_MS ticks, so 1 unit = CLK_FREQ/1000*T_UNIT_MS cycles exactly.
REQ-011 S SHALL be 3 elements of ON 1 unit + OFF 1 unit (6 units total).
- O SHALL be 3 elements of ON 3 units + OFF 1 unit (12 units total).
REQ-012 ON->OFF after the element's ON length.
- OFF->ON with element+1 after 1 unit if element<2.
- OFF->DONE if element==2.
REQ-013 Pin_Out SHALL first go high on the cycle after Start_Sig is sampled non-zero (1-cycle latency).
- Pin_Out SHALL go low on the first cycle of OFF.
REQ-014 In ON with TONE_HZ>0: Pin_Out SHALL toggle every CLK_FREQ/(2*TONE_HZ) cycles, starting high at each ON entry.
- In ON with TONE_HZ=0: Pin_Out SHALL stay constant high.
REQ-015 DONE: Done_Sig=1 and Pin_Out=0; go to WAIT_REL next cycle.
- WAIT_REL: hold Done_Sig=1 until Start_Sig==2'b00, then Done_Sig=0 and go to IDLE.
- The block SHALL NOT restart while Start_Sig remains non-zero after Done_Sig.
REQ-016 Start_Sig value changes to another non-zero value during ON/OFF SHALL be ignored; the latched command governs.
REQ-017 Start_Sig dropping to 2'b00 during ON/OFF SHALL abort:
- Pin_Out=0 next cycle, return to IDLE, no Done_Sig pulse.
REQ-018 Counter widths SHALL be sized by $clog2 of their terminal counts; terminal counts SHALL compare exactly, with no wrap-around.

Reset
REQ-019 RSTn low SHALL force state IDLE, Pin_Out=0, Done_Sig=0, and all counters and the latched command to 0 immediately.
- Reset mid-sequence SHALL silence the buzzer with no Done_Sig.
REQ-020 After RSTn release, the first possible start SHALL be on the first clock edge where Start_Sig != 0.

Structure
REQ-021 The shared package SHALL hold CMD_S=2'b10, CMD_O=2'b01, CMD_NONE=2'b00, the state encoding, and the element counts (3 elements; dot=1, dash=3, gap=1 units).
REQ-022 The ms prescaler SHALL be a sub-module buzzer_ms_tick (CLK, RSTn, clear, tick pulse), parameterised by CLK_FREQ.

Verification
REQ-023 Bench parameters: CLK_FREQ=10_000, T_UNIT_MS=2, TONE_HZ=0 (1 unit = 20 cycles).
REQ-024 Start_Sig=10 held -> Pin_Out high for 20 cycles, low for 20, three times; Done_Sig rises 120 cycles after the start sample; Start_Sig=00 -> Done_Sig low next cycle, state IDLE.
REQ-025 Start_Sig=01 held -> three high pulses of 60 cycles, each followed by 20 low; Done_Sig at cycle 240; Start_Sig held 50 extra cycles -> no restart, Done_Sig stays high.
REQ-026 TONE_HZ=1000, Start_Sig=10 -> during each ON, Pin_Out toggles every 5 cycles, starting high.
REQ-027 Start_Sig=10, dropped to 00 at cycle 30 -> Pin_Out=0 at cycle 31, no Done_Sig, new Start_Sig=01 runs the full O sequence.
REQ-028 RSTn pulsed low at cycle 50 of an O sequence -> Pin_Out=0 and Done_Sig=0 asynchronously; Start_Sig=11 after release -> S timing.
